// File: rtl/button_press_encoder.sv
// Keypad front end: two-flop sync, per-button debounce, one code + strobe per press, chord reject.
// Optional AUTOREPEAT_EN: re-emits press_valid every REPEAT_CYCLES while a single button is held.
module button_press_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_CYCLES   = 50000
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] btn_raw,
    output logic [1:0] bn,
    output logic       press_valid,
    output logic       multi_err,
    output logic       held
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 2");
    end

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic [3:0]         sync1_q, sync1_d;
    logic [3:0]         sync2_q, sync2_d;
    logic [3:0]         stable_q, stable_d;
    logic [3:0]         stable_prev_q, stable_prev_d;
    logic [3:0][CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d       = btn_raw;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        cnt_d         = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            cnt_q         <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Press / chord FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HELD  = 2'b01,
        ST_CHORD = 2'b10
    } state_t;

    state_t     state_q;
    logic [1:0] bn_q;
    logic       press_valid_q;
    logic       multi_err_q;
    logic       held_q;

    logic [3:0] rise;
    logic       single_stable;
    logic       single_rise;
    logic       multi_stable;
    logic       none_stable;

    function automatic logic [1:0] encode(input logic [3:0] v);
        encode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) encode = 2'(i);
        end
    endfunction

    always_comb begin
        rise          = stable_q & ~stable_prev_q;
        single_stable = $onehot(stable_q);
        single_rise   = $onehot(rise);
        none_stable   = (stable_q == 4'b0000);
        // two buttons landing on the same edge must look like a chord, never a press
        multi_stable  = !single_stable && !none_stable;
    end

`ifdef AUTOREPEAT_EN
    localparam int            RW      = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rpt_q;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q       <= ST_IDLE;
            bn_q          <= 2'b00;
            press_valid_q <= 1'b0;
            multi_err_q   <= 1'b0;
            held_q        <= 1'b0;
`ifdef AUTOREPEAT_EN
            rpt_q         <= '0;
`endif
        end else begin
            press_valid_q <= 1'b0;
            multi_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (multi_stable) begin
                        multi_err_q <= 1'b1;
                        held_q      <= 1'b1;
                        state_q     <= ST_CHORD;
                    end else if (single_rise && single_stable) begin
                        press_valid_q <= 1'b1;
                        bn_q          <= encode(rise);
                        held_q        <= 1'b1;
                        state_q       <= ST_HELD;
`ifdef AUTOREPEAT_EN
                        rpt_q         <= '0;
`endif
                    end
                end
                ST_HELD: begin
                    if (multi_stable) begin
                        multi_err_q <= 1'b1;
                        state_q     <= ST_CHORD;
                    end else if (none_stable) begin
                        held_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
`ifdef AUTOREPEAT_EN
                    else if (rpt_q == RPT_MAX) begin
                        press_valid_q <= 1'b1;
                        rpt_q         <= '0;
                    end else begin
                        rpt_q <= rpt_q + 1'b1;
                    end
`endif
                end
                ST_CHORD: begin
                    if (none_stable) begin
                        held_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    held_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bn          = bn_q;
    assign press_valid = press_valid_q;
    assign multi_err   = multi_err_q;
    assign held        = held_q;

endmodule

// File: tb/tb_button_press_encoder.sv
// Bench for button_press_encoder: directed keypad scenarios plus random button traffic,
// every cycle checked against a behavioural model of the press/chord rules.
module tb_button_press_encoder;

    localparam int D = 4;
    localparam int R = 8;

    logic       clock;
    logic       clear;
    logic [3:0] btn_raw;
    logic [1:0] bn;
    logic       press_valid;
    logic       multi_err;
    logic       held;

    button_press_encoder #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .clock       (clock),
        .clear       (clear),
        .btn_raw     (btn_raw),
        .bn          (bn),
        .press_valid (press_valid),
        .multi_err   (multi_err),
        .held        (held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    int pv_count, me_count, held_count, pv_first;
    logic [1:0] last_bn;

    // reference model state
    logic [3:0] m_s1, m_s2, m_stable, m_prev;
    int         m_run [4];
    bit         m_holding, m_chord;
    int         m_held_cycles;
    logic [1:0] m_bn;
    logic       m_pv, m_me;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] button_index(input logic [3:0] v);
        case (v)
            4'b0001: return 2'd0;
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_holding = 0; m_chord = 0; m_held_cycles = 0;
        m_bn = 2'b00; m_pv = 0; m_me = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic clr);
        logic [3:0] st_old, prev_old, s2_old, rise;
        int         n_st;
        if (clr) begin
            model_reset();
            return;
        end
        st_old   = m_stable;
        prev_old = m_prev;
        s2_old   = m_s2;
        m_s2     = m_s1;
        m_s1     = raw;
        // a level is accepted after D consecutive edges seeing it differ from the stable value
        for (int i = 0; i < 4; i++) begin
            if (s2_old[i] != st_old[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_stable[i] = s2_old[i];
                    m_run[i]    = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_prev = st_old;
        rise   = st_old & ~prev_old;
        n_st   = $countones(st_old);
        m_pv   = 0;
        m_me   = 0;
        if (m_chord) begin
            if (n_st == 0) m_chord = 0;
        end else if (m_holding) begin
            if (n_st >= 2) begin
                m_me = 1; m_holding = 0; m_chord = 1;
            end else if (n_st == 0) begin
                m_holding = 0;
            end else begin
`ifdef AUTOREPEAT_EN
                m_held_cycles++;
                if (m_held_cycles % R == 0) m_pv = 1;
`endif
            end
        end else begin
            if (n_st >= 2) begin
                m_me = 1; m_chord = 1;
            end else if ($countones(rise) == 1 && n_st == 1) begin
                m_pv = 1; m_bn = button_index(rise); m_holding = 1; m_held_cycles = 0;
            end
        end
    endtask

    task automatic step(input logic [3:0] b, input logic clr);
        btn_raw = b;
        clear   = clr;
        @(posedge clock);
        edge_no++;
        model_edge(b, clr);
        @(negedge clock);
        check("bn", {6'd0, bn}, {6'd0, m_bn});
        check("press_valid", {7'd0, press_valid}, {7'd0, m_pv});
        check("multi_err", {7'd0, multi_err}, {7'd0, m_me});
        check("held", {7'd0, held}, {7'd0, (m_holding || m_chord)});
        check("strobe_excl", {7'd0, press_valid & multi_err}, 8'd0);
        if (press_valid) begin
            pv_count++;
            last_bn = bn;
            if (pv_first < 0) pv_first = edge_no;
        end
        if (multi_err) me_count++;
        if (held) held_count++;
    endtask

    task automatic clear_counts();
        pv_count = 0; me_count = 0; held_count = 0; pv_first = -1;
    endtask

    task automatic steps(input logic [3:0] b, input int n);
        for (int k = 0; k < n; k++) step(b, 1'b0);
    endtask

    initial begin
        int start_edge;
        model_reset();
        clear_counts();
        last_bn = 2'b00;
        btn_raw = 4'b0000;
        clear   = 1'b1;

        // 1: clear for 3 edges, then idle up to edge 9
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b1);
        steps(4'b0000, 6);
        check("reset_no_strobe", 8'(pv_count + me_count + held_count), 8'd0);

        // 2: button 2 from edge 10 for 20 cycles
        clear_counts();
        steps(4'b0100, 20);
        steps(4'b0000, 12);
        check("t2_pv_count", 8'(pv_count), 8'd1);
        check("t2_pv_edge", 8'(pv_first), 8'd16);
        check("t2_bn", {6'd0, last_bn}, 8'd2);
        check("t2_held_cycles", 8'(held_count), 8'd20);

        // 3: bounce on button 1 then a solid press
        clear_counts();
        steps(4'b0010, 3);
        steps(4'b0000, 2);
        start_edge = edge_no + 1;
        steps(4'b0010, 20);
        steps(4'b0000, 12);
        check("t3_pv_count", 8'(pv_count), 8'd1);
        check("t3_pv_edge", 8'(pv_first - start_edge), 8'(D + 2));
        check("t3_bn", {6'd0, last_bn}, 8'd1);

        // 4: chord of buttons 0 and 3 on the same edge
        clear_counts();
        steps(4'b1001, 10);
        steps(4'b0000, 12);
        check("t4_me_count", 8'(me_count), 8'd1);
        check("t4_pv_count", 8'(pv_count), 8'd0);
        check("t4_held_cycles", 8'(held_count), 8'd10);
        check("t4_bn_kept", {6'd0, bn}, 8'd1);

        // 5: clear mid-debounce while button 3 stays down
        clear_counts();
        steps(4'b1000, 3);
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        check("t5_no_strobe", 8'(pv_count + me_count), 8'd0);
        start_edge = edge_no + 1;
        steps(4'b1000, 12);
        steps(4'b0000, 12);
        check("t5_pv_count", 8'(pv_count), 8'd1);
        check("t5_pv_edge", 8'(pv_first - start_edge), 8'(D + 2));
        check("t5_bn", {6'd0, last_bn}, 8'd3);

        // 6: long hold on button 0
        clear_counts();
        start_edge = edge_no + 1;
        steps(4'b0001, 30);
        steps(4'b0000, 12);
`ifdef AUTOREPEAT_EN
        check("t6_pv_count", 8'(pv_count), 8'd4);
`else
        check("t6_pv_count", 8'(pv_count), 8'd1);
`endif
        check("t6_pv_edge", 8'(pv_first - start_edge), 8'(D + 2));
        check("t6_bn", {6'd0, last_bn}, 8'd0);
        check("t6_me_count", 8'(me_count), 8'd0);

        // random traffic: idle, single presses, chords, bounces and occasional clear
        for (int seg = 0; seg < 150; seg++) begin
            int         len;
            logic [3:0] pat;
            logic       clr;
            len = $urandom_range(1, 14);
            case ($urandom_range(0, 5))
                0, 1:    pat = 4'b0000;
                2, 3:    pat = 4'b0001 << $urandom_range(0, 3);
                default: pat = 4'($urandom);
            endcase
            clr = ($urandom_range(0, 29) == 0);
            for (int k = 0; k < len; k++) step(pat, clr && (k == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
